// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Encodings mirror the 9-bit register-file processor's instruction word.
package seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_LOAD      = 4'd2,
    S_IMM_FETCH = 4'd3,
    S_IMM_LOAD  = 4'd4,
    S_ISSUE     = 4'd5,
    S_EXEC      = 4'd6,
    S_HALTED    = 4'd7,
    S_FAULT     = 4'd8
  } seq_state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int X_HI  = 5;
  localparam int X_LO  = 3;
  localparam int Y_HI  = 2;
  localparam int Y_LO  = 0;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: clear/enable counter, terminal count on the
// TIMEOUT-th enabled cycle since the last clear.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;
  logic [W-1:0] last;

  assign last = W'(TIMEOUT - 1);
  assign tc   = en && (count == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != last)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Program sequencer: fetches ROM words, issues them to the processor,
// waits for Done under a watchdog, stops on HALT or timeout.
module instr_seq_ctrl
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic [8:0]        proc_din,
  output logic              proc_run,
  input  logic              proc_done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        retired,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [3:0]        state
);

  localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2);

  seq_state_t        cur_state;
  seq_state_t        next_state;
  logic [ADDR_W-1:0] pc_next;
  logic [7:0]        retired_next;
  logic [8:0]        instr_q;
  logic [8:0]        imm_q;
  logic [2:0]        load_op;
  logic              is_mvi;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_tc;

  assign load_op = rom_data[OP_HI:OP_LO];
  assign is_mvi  = (instr_q[OP_HI:OP_LO] == OP_MVI);
  assign wd_clr  = (cur_state == S_ISSUE);
  assign wd_en   = (cur_state == S_EXEC);
  assign state   = cur_state;

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en (wd_en),
    .tc (wd_tc)
  );

  always_comb begin
    next_state   = cur_state;
    pc_next      = pc;
    retired_next = retired;
    unique case (cur_state)
      S_IDLE, S_HALTED, S_FAULT: begin
        if (start) begin
          next_state   = S_FETCH;
          pc_next      = '0;
          retired_next = '0;
        end
      end
      S_FETCH: next_state = S_LOAD;
      S_LOAD: begin
        unique case (1'b1)
          (load_op == OP_HALT): next_state = S_HALTED;
          (load_op == OP_MVI):  next_state = S_IMM_FETCH;
          default:              next_state = S_ISSUE;
        endcase
      end
      S_IMM_FETCH: next_state = S_IMM_LOAD;
      S_IMM_LOAD:  next_state = S_ISSUE;
      S_ISSUE:     next_state = S_EXEC;
      S_EXEC: begin
        // Done wins over a same-cycle watchdog expiry.
        if (proc_done) begin
          next_state   = S_FETCH;
          pc_next      = pc + (is_mvi ? STEP2 : STEP1);
          retired_next = retired + 8'd1;
        end else if (wd_tc) begin
          next_state = S_FAULT;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S_IDLE;
      pc        <= '0;
      retired   <= '0;
      rom_addr  <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      proc_din  <= '0;
      proc_run  <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= next_state;
      pc        <= pc_next;
      retired   <= retired_next;
      // Address is launched on entry so data lands in LOAD/IMM_LOAD.
      if (next_state == S_FETCH) begin
        rom_addr <= pc_next;
      end else if (next_state == S_IMM_FETCH) begin
        rom_addr <= pc + STEP1;
      end
      if (cur_state == S_LOAD) begin
        instr_q <= rom_data;
      end
      if (cur_state == S_IMM_LOAD) begin
        imm_q <= rom_data;
      end
      proc_run <= (cur_state == S_ISSUE);
      if (cur_state == S_ISSUE) begin
        proc_din <= instr_q;
      end else if (cur_state == S_EXEC) begin
        proc_din <= is_mvi ? imm_q : instr_q;
      end
      busy   <= !(next_state inside {S_IDLE, S_HALTED, S_FAULT});
      halted <= (next_state == S_HALTED);
      fault  <= (next_state == S_FAULT);
    end
  end

endmodule

// File: doc/instr_seq_ctrl.md
# instr_seq_ctrl

Instruction sequencer that runs a program stored in a synchronous ROM on the 9-bit register-file processor. It fetches each instruction word, plus the immediate word for `mvi`, and presents it on the processor's `DIN`. It pulses `run`, waits for `Done` under a watchdog, advances the program counter, and stops on a halt opcode or a timeout. It sits between the program ROM and the processor, and is the only driver of the processor's `DIN` and `run`.

## Interface
Parameters:
- `ADDR_W`, default 5: ROM address width; program space is 2^ADDR_W words.
- `TIMEOUT`, default 15: maximum cycles to wait for `Done` after `run` before faulting.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: level; sampled in IDLE, HALTED or FAULT to begin execution at address 0.
- `rom_addr`, output, ADDR_W: ROM read address.
- `rom_data`, input, 9: ROM read data; valid one cycle after `rom_addr`.
- `proc_din`, output, 9: drives processor `DIN`.
- `proc_run`, output, 1: drives processor `run`; one-cycle pulse per instruction.
- `proc_done`, input, 1: processor `Done`.
- `pc`, output, ADDR_W: address of the current instruction.
- `retired`, output, 8: count of completed instructions; wraps modulo 256.
- `busy`, output, 1: high in every state except IDLE, HALTED and FAULT.
- `halted`, output, 1: high in HALTED.
- `fault`, output, 1: high in FAULT.
- `state`, output, 4: current state encoding, for debug.

## Operation
- Instruction word is `{op[8:6], x[5:3], y[2:0]}`.
  - op 000 = mv, 001 = mvi, 010 = add, 011 = sub.
  - op 111 = HALT; HALT is consumed by the sequencer and never sent to the processor.
  - ops 100–110 are forwarded unchanged; the processor defines their behaviour.
- States: IDLE(0), FETCH(1), LOAD(2), IMM_FETCH(3), IMM_LOAD(4), ISSUE(5), EXEC(6), HALTED(7), FAULT(8).
- IDLE: on `start`, clear `pc` and `retired`, go to FETCH.
- FETCH: `rom_addr = pc`; go to LOAD.
- LOAD: capture `rom_data` into `instr_q`.
  - op = HALT → HALTED.
  - op = mvi → IMM_FETCH.
  - any other op → ISSUE.
- IMM_FETCH: `rom_addr = pc+1` (modulo 2^ADDR_W); go to IMM_LOAD.
- IMM_LOAD: capture `rom_data` into `imm_q`; go to ISSUE.
- ISSUE: `proc_din = instr_q`, `proc_run = 1`, clear watchdog; go to EXEC. `proc_done` is ignored in ISSUE.
- EXEC:
  - `proc_din` = `imm_q` for mvi, `instr_q` otherwise.
  - `proc_run` = 0; watchdog increments each cycle.
  - On `proc_done`: `pc += 2` for mvi, else `pc += 1` (modulo 2^ADDR_W, wrap to 0 is legal); `retired += 1`; go to FETCH.
  - If the watchdog reaches TIMEOUT without `proc_done`: go to FAULT; `pc` holds the faulting address.
- HALTED / FAULT: `pc` and `retired` hold; `start` restarts exactly as from IDLE.
- `start` in any busy state is ignored.
- `proc_done` in any state other than EXEC is ignored.
- `proc_done` on the same cycle the watchdog reaches TIMEOUT counts as done; no fault.
- `rom_addr` holds its last value outside FETCH and IMM_FETCH.
- `proc_din` holds its last value outside ISSUE and EXEC.

## Timing
- Reset (asynchronous, `rst` = 0): state = IDLE. `pc`, `rom_addr`, `proc_din`, `retired` and the watchdog are all 0. `proc_run`, `busy`, `halted` and `fault` are all 0. Reset mid-instruction abandons it immediately.
- All outputs are registered.
- Non-mvi instruction: `proc_run` is high 3 cycles after FETCH is entered.
- mvi: `proc_run` is high 5 cycles after FETCH is entered; `imm_q` is on `proc_din` from the cycle after `proc_run` until `proc_done`.
- Done → next `proc_run`: 4 cycles for a non-mvi next instruction, 6 cycles for mvi.
- Fault is entered on the TIMEOUT-th EXEC cycle with no `proc_done`.

## Structure
- Package `seq_pkg` holds:
  - state enum `seq_state_t`, 4 bits, with the encodings above;
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_HALT`;
  - field slice constants for op, x and y.
- Sub-module `seq_watchdog`: clear/enable counter with terminal-count output, parameterized by TIMEOUT.
- Everything else lives in a single module.

## Test plan
- ROM {mvi R0; 0x005; HALT}, processor model returning Done 2 cycles after run:
  - `proc_din` = 0x040, then 0x005;
  - ends with `halted` = 1, `pc` = 2, `retired` = 1.
- ROM {0x040, 0x003, 0x048, 0x004, 0x080 (add R0,R0), 0x1C0}: exactly 3 `proc_run` pulses; `retired` = 3; `pc` = 5.
- Processor never asserts Done:
  - `fault` = 1 exactly 15 cycles after `proc_run`; `pc` = 0;
  - then `start` restarts: `busy` = 1 with `rom_addr` = 0 at FETCH.
- Program with no HALT filling all 32 words of mv: `pc` wraps 31 → 0 and `retired` keeps counting; no fault.
- `rst` low during EXEC of an mvi: all outputs return to their reset values asynchronously; `start` after reset re-runs from address 0.
- `proc_done` pulsed during FETCH and ISSUE, and `start` pulsed during EXEC: no state change; `retired` unchanged.
